// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared tracking-entry type and forward-select width helper for the hazard unit
package core_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       load;
  } trk_entry_t;

  localparam trk_entry_t TRK_BUBBLE = '{valid: 1'b0, rd: 5'd0, load: 1'b0};

  // fwd selects 0 (register file) or a stage index 1..depth
  function automatic int fwd_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - per-source youngest-match search over the tracking stages
// Forwarding decisions are compiled in only with HAZARD_CTRL_FWD_EN defined.
module hazard_match
  import core_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int FW    = fwd_w(DEPTH)
) (
  input  logic                   use_src,
  input  logic [4:0]             rs,
  input  trk_entry_t [DEPTH:1]   trk,
  output logic [FW-1:0]          fwd,
  output logic                   hazard
);

  logic          hit;
  logic          is_load;
  logic [FW-1:0] idx;

  // Scan oldest to youngest so the last hit written is the youngest match.
  always_comb begin
    hit     = 1'b0;
    is_load = 1'b0;
    idx     = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (use_src && rs != 5'd0 && trk[k].valid && trk[k].rd == rs) begin
        hit     = 1'b1;
        is_load = trk[k].load;
        idx     = FW'(k);
      end
    end
  end

`ifdef HAZARD_CTRL_FWD_EN
  logic fwd_ok;

  // A load result only exists once the entry has reached the last tracked stage.
  assign fwd_ok = !is_load || (idx == FW'(DEPTH));
  assign fwd    = (hit && fwd_ok) ? idx : '0;
  assign hazard = hit && !fwd_ok;
`else
  logic [FW:0] unused_sel;

  assign unused_sel = {idx, is_load};
  assign fwd        = '0;
  assign hazard     = hit;
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard unit: stall, flush and operand-forward selection
// Forwarding is enabled by defining HAZARD_CTRL_FWD_EN; otherwise any match stalls.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int NREG  = 32,
  parameter int CW    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dec_valid,
  input  logic [4:0]                   dec_rs1,
  input  logic [4:0]                   dec_rs2,
  input  logic                         dec_use1,
  input  logic                         dec_use2,
  input  logic [4:0]                   dec_rd,
  input  logic                         dec_wr,
  input  logic                         dec_load,
  input  logic                         br_taken,
  output logic                         stall_f,
  output logic                         stall_d,
  output logic                         flush_d,
  output logic                         flush_e,
  output logic [$clog2(DEPTH+1)-1:0]   fwd1,
  output logic [$clog2(DEPTH+1)-1:0]   fwd2,
  output logic [CW-1:0]                stall_cnt
);

  localparam int FW = fwd_w(DEPTH);

  trk_entry_t [DEPTH:1] trk;
  trk_entry_t           dec_entry;
  logic                 haz1, haz2;
  logic [FW-1:0]        m_fwd1, m_fwd2;
  logic                 stall;
  logic                 dec_tracked;

  hazard_match #(.DEPTH(DEPTH), .FW(FW)) u_match1 (
    .use_src (dec_use1),
    .rs      (dec_rs1),
    .trk     (trk),
    .fwd     (m_fwd1),
    .hazard  (haz1)
  );

  hazard_match #(.DEPTH(DEPTH), .FW(FW)) u_match2 (
    .use_src (dec_use2),
    .rs      (dec_rs2),
    .trk     (trk),
    .fwd     (m_fwd2),
    .hazard  (haz2)
  );

  // Outputs are held quiet while reset is asserted so nothing leaks from stale state.
  assign stall   = reset && dec_valid && (haz1 || haz2) && !br_taken;
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_d = reset && br_taken;
  assign flush_e = reset && br_taken;
  assign fwd1    = reset ? m_fwd1 : '0;
  assign fwd2    = reset ? m_fwd2 : '0;

  assign dec_tracked = dec_valid && dec_wr && dec_rd != 5'd0 && (int'(dec_rd) < NREG);
  assign dec_entry   = '{valid: 1'b1, rd: dec_rd, load: dec_load};

  always_ff @(posedge clk) begin
    if (!reset) begin
      trk       <= '0;
      stall_cnt <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        trk[k] <= trk[k-1];
      end
      // A redirect makes the instruction entering EX wrong-path, so it becomes a bubble.
      trk[1] <= (dec_tracked && !stall && !br_taken) ? dec_entry : TRK_BUBBLE;
      if (stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (vector table, directed corners, random vs model)
module tb_hazard_ctrl;

  localparam int DEPTH = 3;
  localparam int NREG  = 32;
  localparam int CW    = 4;
  localparam int FW    = $clog2(DEPTH + 1);
`ifdef HAZARD_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          dec_valid = 1'b0;
  logic [4:0]    dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic          dec_use1 = 1'b0, dec_use2 = 1'b0, dec_wr = 1'b0, dec_load = 1'b0;
  logic          br_taken = 1'b0;
  logic          stall_f, stall_d, flush_d, flush_e;
  logic [FW-1:0] fwd1, fwd2;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.DEPTH(DEPTH), .NREG(NREG), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .dec_valid (dec_valid),
    .dec_rs1   (dec_rs1),
    .dec_rs2   (dec_rs2),
    .dec_use1  (dec_use1),
    .dec_use2  (dec_use2),
    .dec_rd    (dec_rd),
    .dec_wr    (dec_wr),
    .dec_load  (dec_load),
    .br_taken  (br_taken),
    .stall_f   (stall_f),
    .stall_d   (stall_d),
    .flush_d   (flush_d),
    .flush_e   (flush_e),
    .fwd1      (fwd1),
    .fwd2      (fwd2),
    .stall_cnt (stall_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: list of issued writers stamped with their issue cycle; age = stage.
  typedef struct {
    int         cyc;
    logic [4:0] rd;
    bit         load;
  } wr_rec_t;

  wr_rec_t hist[$];
  int      now   = 0;
  int      m_cnt = 0;
  bit      e_stall, e_flush;
  int      e_fwd1, e_fwd2;

  // Values observed at the most recent sample point.
  int s_stall, s_stall_f, s_flush, s_flush_e, s_fwd1, s_fwd2, s_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void src_eval(input logic u, input logic [4:0] rs, output int f, output bit h);
    int best_age;
    bit best_load;
    f = 0;
    h = 1'b0;
    best_age = 0;
    best_load = 1'b0;
    if (!u || rs == 5'd0) return;
    foreach (hist[i]) begin
      int age;
      age = now - hist[i].cyc;
      if (age >= 1 && age <= DEPTH && hist[i].rd == rs && (best_age == 0 || age < best_age)) begin
        best_age  = age;
        best_load = hist[i].load;
      end
    end
    if (best_age == 0) return;
    if (FWD && (!best_load || best_age == DEPTH)) f = best_age;
    else h = 1'b1;
  endfunction

  task automatic model_eval();
    int f1, f2;
    bit h1, h2;
    src_eval(dec_use1, dec_rs1, f1, h1);
    src_eval(dec_use2, dec_rs2, f2, h2);
    if (!reset) begin
      e_stall = 1'b0; e_flush = 1'b0; e_fwd1 = 0; e_fwd2 = 0;
    end else begin
      e_flush = br_taken;
      e_stall = dec_valid && (h1 || h2) && !br_taken;
      e_fwd1  = f1;
      e_fwd2  = f2;
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      hist.delete();
      m_cnt = 0;
    end else begin
      if (e_stall && m_cnt < (1 << CW) - 1) m_cnt++;
      if (dec_valid && dec_wr && dec_rd != 5'd0 && int'(dec_rd) < NREG && !e_stall && !br_taken)
        hist.push_back('{cyc: now, rd: dec_rd, load: dec_load});
    end
    now++;
    while (hist.size() > 0 && now - hist[0].cyc > DEPTH) void'(hist.pop_front());
  endtask

  // One clock: sample and compare on the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    s_stall = stall_d; s_stall_f = stall_f; s_flush = flush_d; s_flush_e = flush_e;
    s_fwd1 = fwd1; s_fwd2 = fwd2; s_cnt = stall_cnt;
    check("m_stall_f", s_stall_f, e_stall);
    check("m_stall_d", s_stall, e_stall);
    check("m_flush_d", s_flush, e_flush);
    check("m_flush_e", s_flush_e, e_flush);
    check("m_fwd1", s_fwd1, e_fwd1);
    check("m_fwd2", s_fwd2, e_fwd2);
    check("m_stall_cnt", s_cnt, m_cnt);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_dec(input bit v, input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                         input bit u2, input logic [4:0] rd, input bit wr, input bit ld, input bit br);
    dec_valid = v; dec_rs1 = rs1; dec_use1 = u1; dec_rs2 = rs2; dec_use2 = u2;
    dec_rd = rd; dec_wr = wr; dec_load = ld; br_taken = br;
  endtask

  task automatic idle();
    set_dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  // Producer issued, then gap idle cycles, then a consumer; expectations at the consumer cycle.
  typedef struct {
    logic [4:0] p_rd;
    bit         p_wr;
    bit         p_load;
    int         gap;
    logic [4:0] rs1;
    bit         u1;
    logic [4:0] rs2;
    bit         u2;
    int         f1;
    int         f2;
    bit         s_fwd;
    bit         s_nofwd;
  } vec_t;

  vec_t tbl[12];
  int   n;

  initial begin
    tbl[0]  = '{5'd5, 1, 0, 0, 5'd5, 1, 5'd0, 0, 1, 0, 0, 1};
    tbl[1]  = '{5'd5, 1, 0, 1, 5'd0, 0, 5'd5, 1, 0, 2, 0, 1};
    tbl[2]  = '{5'd5, 1, 0, 2, 5'd5, 1, 5'd0, 0, 3, 0, 0, 1};
    tbl[3]  = '{5'd5, 1, 0, 3, 5'd5, 1, 5'd0, 0, 0, 0, 0, 0};
    tbl[4]  = '{5'd7, 1, 1, 0, 5'd7, 1, 5'd0, 0, 0, 0, 1, 1};
    tbl[5]  = '{5'd7, 1, 1, 1, 5'd0, 0, 5'd7, 1, 0, 0, 1, 1};
    tbl[6]  = '{5'd7, 1, 1, 2, 5'd7, 1, 5'd7, 1, 3, 3, 0, 1};
    tbl[7]  = '{5'd0, 1, 0, 0, 5'd0, 1, 5'd0, 1, 0, 0, 0, 0};
    tbl[8]  = '{5'd5, 1, 0, 0, 5'd5, 0, 5'd5, 0, 0, 0, 0, 0};
    tbl[9]  = '{5'd9, 1, 0, 0, 5'd3, 1, 5'd4, 1, 0, 0, 0, 0};
    tbl[10] = '{5'd5, 1, 0, 0, 5'd5, 1, 5'd5, 1, 1, 1, 0, 1};
    tbl[11] = '{5'd5, 0, 0, 0, 5'd5, 1, 5'd0, 0, 0, 0, 0, 0};

    // Reset state
    do_reset();
    idle();
    cycle();
    check("rst_stall_cnt", s_cnt, 0);
    check("rst_stall_d", s_stall, 0);
    check("rst_flush_d", s_flush, 0);
    check("rst_fwd1", s_fwd1, 0);

    foreach (tbl[i]) begin
      do_reset();
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, tbl[i].p_rd, tbl[i].p_wr, tbl[i].p_load, 1'b0);
      cycle();
      for (int g = 0; g < tbl[i].gap; g++) begin
        idle();
        cycle();
      end
      set_dec(1'b1, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, 5'd0, 1'b0, 1'b0, 1'b0);
      cycle();
      check($sformatf("tbl%0d_stall", i), s_stall, FWD ? int'(tbl[i].s_fwd) : int'(tbl[i].s_nofwd));
      check($sformatf("tbl%0d_fwd1", i), s_fwd1, FWD ? tbl[i].f1 : 0);
      check($sformatf("tbl%0d_fwd2", i), s_fwd2, FWD ? tbl[i].f2 : 0);
    end

    // ALU-use
    do_reset();
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cycle();
    set_dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (s_stall == 0) break;
      n++;
    end
    check("alu_use_stalls", n, FWD ? 0 : 3);
    check("alu_use_fwd1", s_fwd1, FWD ? 1 : 0);
    check("alu_use_cnt", s_cnt, FWD ? 0 : 3);

    // Load-use
    do_reset();
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    cycle();
    set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (s_stall == 0) break;
      n++;
    end
    check("load_use_stalls", n, FWD ? 2 : 3);
    check("load_use_fwd1", s_fwd1, FWD ? 3 : 0);
    check("load_use_cnt", s_cnt, FWD ? 2 : 3);

    // Youngest match wins over an older load to the same register
    do_reset();
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    cycle();
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cycle();
    set_dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("youngest_fwd1", s_fwd1, FWD ? 1 : 0);
    check("youngest_stall", s_stall, FWD ? 0 : 1);

    // Load-use stall coincident with a redirect
    do_reset();
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    cycle();
    set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    cycle();
    check("br_flush_d", s_flush, 1);
    check("br_flush_e", s_flush_e, 1);
    check("br_stall_d", s_stall, 0);
    check("br_stall_f", s_stall_f, 0);
    set_dec(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("br_stage1_fwd1", s_fwd1, 0);
    check("br_stage1_stall", s_stall, 0);

    // Stall counter saturation
    do_reset();
    for (int r = 0; r < 10; r++) begin
      set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
      cycle();
      set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
        cycle();
        if (s_stall == 0) break;
      end
      if (r == 0) check("sat_first_round", s_cnt, FWD ? 2 : 3);
    end
    idle();
    cycle();
    check("sat_stall_cnt", s_cnt, 15);

    // Reset applied mid-stall
    do_reset();
    set_dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    cycle();
    set_dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("midrst_pre_stall", s_stall, 1);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    check("midrst_stall_d", s_stall, 0);
    check("midrst_stall_f", s_stall_f, 0);
    check("midrst_flush", s_flush, 0);
    check("midrst_fwd1", s_fwd1, 0);
    check("midrst_cnt", s_cnt, 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_dec(($urandom_range(0, 4) != 0),
              5'($urandom_range(0, 3)), 1'($urandom),
              5'($urandom_range(0, 3)), 1'($urandom),
              5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 7) == 0));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
